// File: rtl/mux8_pkg.sv
// mux8_pkg: shared sizes and the select type for the registered 8:1 mux.
package mux8_pkg;

  localparam int N_IN     = 8;
  localparam int SEL_W    = 3;
  localparam int LO_SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux8_pkg

// File: rtl/mux4x1_lane.sv
// mux4x1_lane: purely combinational 4:1 lane selector, DATA_W bits per lane.
// Lane k sits at lanes_i[k*DATA_W +: DATA_W], lane 0 at the LSBs.
module mux4x1_lane
  import mux8_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [LO_SEL_W-1:0]   sel_i,
  input  logic [4*DATA_W-1:0]   lanes_i,
  output logic [DATA_W-1:0]     lane_o
);

  // Pick one of the four lanes; every select value maps to a lane.
  always_comb begin
    lane_o = '0;
    case (sel_i)
      2'd0:    lane_o = lanes_i[0*DATA_W +: DATA_W];
      2'd1:    lane_o = lanes_i[1*DATA_W +: DATA_W];
      2'd2:    lane_o = lanes_i[2*DATA_W +: DATA_W];
      default: lane_o = lanes_i[3*DATA_W +: DATA_W];
    endcase
  end

endmodule : mux4x1_lane

// File: rtl/mux8x1_using_4x1.sv
// mux8x1_using_4x1: registered 8:1 selector built from two 4:1 muxes and a
// final 2:1 stage. sel[1:0] steers both 4:1 muxes, sel[2] picks the high
// (lanes 4-7) or low (lanes 0-3) result.
// Optional macro MUX8_INPUT_REG_EN: registers sel and in ahead of the mux
// tree, giving 2-cycle latency instead of 1.
module mux8x1_using_4x1
  import mux8_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  sel_t                     sel,
  input  logic [N_IN*DATA_W-1:0]   in,
  output logic [DATA_W-1:0]        out
);

  localparam int HALF_W = (N_IN / 2) * DATA_W;

  sel_t                   muxSel;
  logic [N_IN*DATA_W-1:0] muxIn;
  logic [DATA_W-1:0]      loLane;
  logic [DATA_W-1:0]      hiLane;
  logic [DATA_W-1:0]      out_d;
  logic [DATA_W-1:0]      out_q;

`ifdef MUX8_INPUT_REG_EN
  sel_t                   sel_q;
  logic [N_IN*DATA_W-1:0] in_q;

  // Capture sel and in one cycle ahead of the mux tree; cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= '0;
      in_q  <= '0;
    end else begin
      sel_q <= sel;
      in_q  <= in;
    end
  end

  assign muxSel = sel_q;
  assign muxIn  = in_q;
`else
  assign muxSel = sel;
  assign muxIn  = in;
`endif

  mux4x1_lane #(.DATA_W(DATA_W)) uLoMux (
    .sel_i   (muxSel[LO_SEL_W-1:0]),
    .lanes_i (muxIn[HALF_W-1:0]),
    .lane_o  (loLane)
  );

  mux4x1_lane #(.DATA_W(DATA_W)) uHiMux (
    .sel_i   (muxSel[LO_SEL_W-1:0]),
    .lanes_i (muxIn[N_IN*DATA_W-1:HALF_W]),
    .lane_o  (hiLane)
  );

  // Final 2:1 stage: top select bit chooses between the two halves.
  always_comb begin
    out_d = muxSel[SEL_W-1] ? hiLane : loLane;
  end

  // Output register; reset wins over any selection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : mux8x1_using_4x1

// File: tb/tb_mux8x1_using_4x1.sv
// tb_mux8x1_using_4x1: directed checks of the registered 8:1 mux, default
// build (single output register, 1-cycle latency, DATA_W=1).
module tb_mux8x1_using_4x1;

  logic       clk;
  logic       rstN;
  logic [2:0] selIn;
  logic [7:0] inBus;
  logic       outBit;

  int errorCount;
  int checkCount;

  mux8x1_using_4x1 #(.DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rstN),
    .sel   (selIn),
    .in    (inBus),
    .out   (outBit)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of inputs, then wait past the capturing rising edge.
  task automatic applyStimulus(input logic rstVal, input logic [2:0] selVal,
                               input logic [7:0] inVal);
    rstN  = rstVal;
    selIn = selVal;
    inBus = inVal;
    @(posedge clk);
    #1;
  endtask

  // Compare the registered output against a hand-computed value.
  task automatic checkOutput(input string tag, input logic expVal);
    checkCount++;
    assert (outBit === expVal)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: out=%b expected=%b", tag, outBit, expVal);
    end
  endtask

  initial begin
    logic [7:0] sweepVal;
    errorCount = 0;
    checkCount = 0;
    rstN  = 1'b0;
    selIn = 3'd0;
    inBus = 8'h00;
    @(negedge clk);

    // Reset held two edges with the selected lane high, then release.
    applyStimulus(1'b0, 3'd3, 8'hFF); checkOutput("reset_edge1", 1'b0);
    applyStimulus(1'b0, 3'd3, 8'hFF); checkOutput("reset_edge2", 1'b0);
    applyStimulus(1'b1, 3'd3, 8'hFF); checkOutput("release", 1'b1);

    // Low lanes with in=0000_0101.
    applyStimulus(1'b1, 3'd0, 8'b0000_0101); checkOutput("in05_sel0", 1'b1);
    applyStimulus(1'b1, 3'd1, 8'b0000_0101); checkOutput("in05_sel1", 1'b0);
    applyStimulus(1'b1, 3'd2, 8'b0000_0101); checkOutput("in05_sel2", 1'b1);

    // Sweep in=0..15 with sel=0,1,2 every cycle.
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < 3; s++) begin
        sweepVal = 8'(i);
        applyStimulus(1'b1, 3'(s), sweepVal);
        checkOutput($sformatf("sweep_in%0d_sel%0d", i, s), sweepVal[s]);
      end
    end

    // Upper 4:1 mux and sel[2] routing with in=1010_0000.
    applyStimulus(1'b1, 3'd4, 8'b1010_0000); checkOutput("inA0_sel4", 1'b0);
    applyStimulus(1'b1, 3'd5, 8'b1010_0000); checkOutput("inA0_sel5", 1'b1);
    applyStimulus(1'b1, 3'd6, 8'b1010_0000); checkOutput("inA0_sel6", 1'b0);
    applyStimulus(1'b1, 3'd7, 8'b1010_0000); checkOutput("inA0_sel7", 1'b1);

    // Back-to-back toggling 0<->7 with only lane 7 high.
    applyStimulus(1'b1, 3'd0, 8'h80); checkOutput("toggle_a0", 1'b0);
    applyStimulus(1'b1, 3'd7, 8'h80); checkOutput("toggle_a7", 1'b1);
    applyStimulus(1'b1, 3'd0, 8'h80); checkOutput("toggle_b0", 1'b0);
    applyStimulus(1'b1, 3'd7, 8'h80); checkOutput("toggle_b7", 1'b1);
    applyStimulus(1'b1, 3'd0, 8'h80); checkOutput("toggle_c0", 1'b0);
    applyStimulus(1'b1, 3'd7, 8'h80); checkOutput("toggle_c7", 1'b1);

    // Walking one: selected lane reads 1, neighbouring lane reads 0.
    applyStimulus(1'b1, 3'd0, 8'h01); checkOutput("walk_hit0", 1'b1);
    applyStimulus(1'b1, 3'd1, 8'h01); checkOutput("walk_miss1", 1'b0);
    applyStimulus(1'b1, 3'd1, 8'h02); checkOutput("walk_hit1", 1'b1);
    applyStimulus(1'b1, 3'd3, 8'h08); checkOutput("walk_hit3", 1'b1);
    applyStimulus(1'b1, 3'd4, 8'h08); checkOutput("walk_miss4", 1'b0);
    applyStimulus(1'b1, 3'd4, 8'h10); checkOutput("walk_hit4", 1'b1);
    applyStimulus(1'b1, 3'd0, 8'h10); checkOutput("walk_miss0", 1'b0);
    applyStimulus(1'b1, 3'd6, 8'h40); checkOutput("walk_hit6", 1'b1);
    applyStimulus(1'b1, 3'd2, 8'h40); checkOutput("walk_miss2", 1'b0);
    applyStimulus(1'b1, 3'd2, 8'hFB); checkOutput("walk_zero2", 1'b0);
    applyStimulus(1'b1, 3'd5, 8'hDF); checkOutput("walk_zero5", 1'b0);

    // Reset asserted mid-stream, then the first released edge loads again.
    applyStimulus(1'b0, 3'd7, 8'h80); checkOutput("midreset", 1'b0);
    applyStimulus(1'b1, 3'd7, 8'h80); checkOutput("midrelease", 1'b1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule : tb_mux8x1_using_4x1
